// File: rtl/cpu_pkg.sv
// Shared definitions for the processor front end: opcode encodings, word width
// and the instruction-fetch state encoding.
package cpu_pkg;

    localparam int IW_DEF = 9;

    localparam logic [2:0] OP_MV  = 3'b000;
    localparam logic [2:0] OP_MVI = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_HLT = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_IMM,
        S_IMM_LD,
        S_ISSUE,
        S_WAIT,
        S_HALT
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch_seq.sv
// Instruction issuer: fetches words from a synchronous program ROM, prefetches
// the MVI immediate, and hands each instruction to the controller with run.
module instr_fetch_seq
    import cpu_pkg::*;
#(
    parameter int ADDR_W  = 5,
    parameter int IW      = IW_DEF,
    parameter int TIMEOUT = 15
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              start,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [IW-1:0]     mem_data,
    output logic [IW-1:0]     ir,
    output logic [IW-1:0]     din,
    output logic              run,
    input  logic              done,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              halted,
    output logic              timeout_err,
    output fetch_state_t      state_dbg
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    fetch_state_t     state;
    logic [CNT_W-1:0] wait_cnt;
    logic [2:0]       op;

    // The ROM is addressed straight from pc; the word for pc is on mem_data
    // one cycle later, which is exactly when DECODE / IMM_LD consume it.
    assign mem_addr  = pc;
    assign op        = mem_data[IW-1:IW-3];
    assign state_dbg = state;

    // Handshake: run is high for exactly one cycle (ISSUE) with ir/din valid;
    // ir/din then stay put until done is seen high in WAIT. done in any other
    // state is ignored, and done on the final allowed WAIT cycle wins over the timeout.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state       <= S_IDLE;
            pc          <= '0;
            ir          <= '0;
            din         <= '0;
            run         <= 1'b0;
            busy        <= 1'b0;
            halted      <= 1'b0;
            timeout_err <= 1'b0;
            wait_cnt    <= '0;
        end else begin
            run <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_FETCH;
                        busy  <= 1'b1;
                    end
                end
                S_FETCH: begin
                    state <= S_DECODE;
                end
                S_DECODE: begin
                    ir <= mem_data;
                    pc <= pc + ADDR_W'(1);
                    if (op == OP_HLT) begin
                        state  <= S_HALT;
                        busy   <= 1'b0;
                        halted <= 1'b1;
                    end else if (op == OP_MVI) begin
                        state <= S_IMM;
                    end else begin
                        state <= S_ISSUE;
                        run   <= 1'b1;
                    end
                end
                S_IMM: begin
                    state <= S_IMM_LD;
                end
                S_IMM_LD: begin
                    din   <= mem_data;
                    pc    <= pc + ADDR_W'(1);
                    state <= S_ISSUE;
                    run   <= 1'b1;
                end
                S_ISSUE: begin
                    wait_cnt <= '0;
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (done) begin
                        if (start) begin
                            state <= S_FETCH;
                        end else begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end
                    end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                        wait_cnt    <= CNT_W'(TIMEOUT);
                        timeout_err <= 1'b1;
                        state       <= S_HALT;
                        busy        <= 1'b0;
                        halted      <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                S_HALT: begin
                    state <= S_HALT;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_seq.sv
// Bench for instr_fetch_seq: ROM models, issue-order scoreboard and directed
// programs covering MVI, timeout, wrap, async reset and start gating.
module tb_instr_fetch_seq;
    import cpu_pkg::*;

    localparam int AW  = 5;
    localparam int AW2 = 2;
    localparam int W   = 9;
    localparam int TO  = 15;

    // ---------------- clock / reset / DUTs ----------------
    logic clock, resetn;
    logic start, done, start2, done2;

    logic [AW-1:0]  mem_addr, pc;
    logic [W-1:0]   mem_data, ir, din;
    logic           run, busy, halted, timeout_err;
    fetch_state_t   state_dbg;

    logic [AW2-1:0] mem_addr2, pc2;
    logic [W-1:0]   mem_data2, ir2, din2;
    logic           run2, busy2, halted2, timeout_err2;
    fetch_state_t   state_dbg2;

    logic [W-1:0] rom  [0:31];
    logic [W-1:0] rom2 [0:3];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    instr_fetch_seq #(.ADDR_W(AW), .IW(W), .TIMEOUT(TO)) dut (
        .clock(clock), .resetn(resetn), .start(start),
        .mem_addr(mem_addr), .mem_data(mem_data),
        .ir(ir), .din(din), .run(run), .done(done), .pc(pc),
        .busy(busy), .halted(halted), .timeout_err(timeout_err),
        .state_dbg(state_dbg)
    );

    instr_fetch_seq #(.ADDR_W(AW2), .IW(W), .TIMEOUT(TO)) dut2 (
        .clock(clock), .resetn(resetn), .start(start2),
        .mem_addr(mem_addr2), .mem_data(mem_data2),
        .ir(ir2), .din(din2), .run(run2), .done(done2), .pc(pc2),
        .busy(busy2), .halted(halted2), .timeout_err(timeout_err2),
        .state_dbg(state_dbg2)
    );

    always @(posedge clock) begin
        mem_data  <= rom[mem_addr];
        mem_data2 <= rom2[mem_addr2];
    end

    // ---------------- scoreboard state ----------------
    logic [2*W-1:0] exp_q[$];
    int             exp_pc;
    int             n_cmp = 0;
    int             n_bad = 0;
    int             run_cnt = 0;
    bit             in_flight = 1'b0;
    logic [W-1:0]   held_ir, held_din;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Model: walk the program as the ISA describes it and list (ir, din) per issue.
    task automatic build_exp();
        int p;
        logic [W-1:0] w, d;
        p = 0;
        d = '0;
        exp_q.delete();
        for (int n = 0; n < 32; n++) begin
            w = rom[p];
            p = (p + 1) % 32;
            if (w[8:6] == 3'b111) break;
            if (w[8:6] == 3'b001) begin
                d = rom[p];
                p = (p + 1) % 32;
            end
            exp_q.push_back({w, d});
        end
        exp_pc = p;
    endtask

    // Compare process: every issue must match the model; ir/din held while in flight.
    always @(negedge clock) begin
        logic [2*W-1:0] e;
        if (!resetn) begin
            in_flight = 1'b0;
        end else begin
            if (in_flight) begin
                check("ir_hold", ir, held_ir);
                check("din_hold", din, held_din);
            end
            if (run) begin
                run_cnt++;
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_run: got run with ir=%0h, expected no issue", ir);
                end else begin
                    e = exp_q.pop_front();
                    check("issue_ir", ir, e[2*W-1:W]);
                    check("issue_din", din, e[W-1:0]);
                end
                held_ir   = ir;
                held_din  = din;
                in_flight = 1'b1;
            end else if (done || !busy) begin
                in_flight = 1'b0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        start  = 1'b0;
        done   = 1'b0;
        start2 = 1'b0;
        done2  = 1'b0;
        repeat (2) tick();
        resetn = 1'b1;
        tick();
        run_cnt = 0;
    endtask

    task automatic rom_fill();
        for (int i = 0; i < 32; i++) rom[i] = 9'o700;
    endtask

    task automatic wait_run(input bit second, output int lat);
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if ((second ? run2 : run) === 1'b1) begin
                lat = i;
                break;
            end
        end
        if (lat < 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL run_wait: got no run within 40 cycles, expected a run pulse");
        end
    endtask

    task automatic pulse_done(input bit second, input int n);
        repeat (n) tick();
        if (second) done2 = 1'b1; else done = 1'b1;
        tick();
        done  = 1'b0;
        done2 = 1'b0;
    endtask

    task automatic wait_halt();
        int k;
        k = 0;
        while (halted !== 1'b1 && k < 40) begin
            tick();
            k++;
        end
        if (halted !== 1'b1) begin
            n_cmp++;
            n_bad++;
            $display("FAIL halt_wait: got halted=%b after 40 cycles, expected 1", halted);
        end
    endtask

    // ---------------- directed tests ----------------
    logic [W-1:0] exp_ir2  [0:3];
    logic [W-1:0] exp_din2 [0:3];

    initial begin
        int lat;
        resetn = 1'b1;
        start  = 1'b0;
        done   = 1'b0;
        start2 = 1'b0;
        done2  = 1'b0;
        rom_fill();
        for (int i = 0; i < 4; i++) rom2[i] = 9'o700;
        #2;

        // Program 1: MVI R0,#2 ; MV R1,R0 ; HLT
        rom_fill();
        rom[0] = 9'o100; rom[1] = 9'o002; rom[2] = 9'o010; rom[3] = 9'o700;
        build_exp();
        check("model_count", exp_q.size(), 2);
        check("model_issue0", exp_q[0], {9'o100, 9'o002});
        check("model_issue1", exp_q[1], {9'o010, 9'o002});
        check("model_pc", exp_pc, 4);
        do_reset();
        check("rst_pc", pc, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_ir", ir, 0);
        check("rst_din", din, 0);
        check("rst_run", run, 0);
        check("rst_busy", busy, 0);
        check("rst_halted", halted, 0);
        check("rst_timeout_err", timeout_err, 0);
        start = 1'b1;
        wait_run(1'b0, lat);
        check("mvi_latency", lat, 5);
        check("mvi_ir", ir, 9'o100);
        check("mvi_din", din, 9'd2);
        pulse_done(1'b0, 1);
        wait_run(1'b0, lat);
        check("next_latency", lat, 2);
        check("mv_ir", ir, 9'o010);
        pulse_done(1'b0, 1);
        wait_halt();
        check("p1_halted", halted, 1);
        check("p1_busy", busy, 0);
        check("p1_pc", pc, exp_pc);
        check("p1_runs", run_cnt, 2);
        check("p1_queue_left", exp_q.size(), 0);

        // ADD R1,R1 with done three cycles after run
        rom_fill();
        rom[0] = 9'o211;
        build_exp();
        do_reset();
        start = 1'b1;
        wait_run(1'b0, lat);
        check("add_latency", lat, 3);
        pulse_done(1'b0, 3);
        check("after_done_mem_addr", mem_addr, 1);
        check("after_done_pc", pc, 1);
        wait_halt();
        check("add_runs", run_cnt, 1);
        check("add_pc", pc, 2);

        // Done withheld: timeout after 15 WAIT cycles
        rom_fill();
        rom[0] = 9'o211; rom[1] = 9'o211;
        build_exp();
        do_reset();
        start = 1'b1;
        wait_run(1'b0, lat);
        repeat (TO) tick();
        check("to_err_cycle15", timeout_err, 0);
        check("to_halted_cycle15", halted, 0);
        tick();
        check("to_err", timeout_err, 1);
        check("to_halted", halted, 1);
        check("to_run", run, 0);
        check("to_busy", busy, 0);
        done = 1'b1;
        repeat (3) tick();
        done = 1'b0;
        check("to_frozen_halted", halted, 1);
        check("to_frozen_pc", pc, 1);
        check("to_runs", run_cnt, 1);

        // Done on exactly cycle 15: no error
        rom_fill();
        rom[0] = 9'o211;
        build_exp();
        do_reset();
        start = 1'b1;
        wait_run(1'b0, lat);
        pulse_done(1'b0, TO);
        check("edge_err", timeout_err, 0);
        check("edge_busy", busy, 1);
        wait_halt();
        check("edge_err_end", timeout_err, 0);
        check("edge_pc", pc, 2);

        // ADDR_W=2: MVI at address 3 takes its immediate from address 0
        rom2[0] = 9'o005; rom2[1] = 9'o301; rom2[2] = 9'o202; rom2[3] = 9'o170;
        exp_ir2[0]  = 9'o005; exp_ir2[1]  = 9'o301; exp_ir2[2]  = 9'o202; exp_ir2[3]  = 9'o170;
        exp_din2[0] = 9'd0;   exp_din2[1] = 9'd0;   exp_din2[2] = 9'd0;   exp_din2[3] = 9'd5;
        do_reset();
        start2 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_run(1'b1, lat);
            check("wrap_ir", ir2, exp_ir2[i]);
            check("wrap_din", din2, exp_din2[i]);
            if (i == 3) start2 = 1'b0;
            pulse_done(1'b1, 1);
        end
        check("wrap_pc", pc2, 1);
        check("wrap_busy", busy2, 0);
        check("wrap_main_runs", run_cnt, 0);

        // Async reset during WAIT of SUB, then during ISSUE
        rom_fill();
        rom[0] = 9'o320;
        build_exp();
        do_reset();
        start = 1'b1;
        wait_run(1'b0, lat);
        repeat (2) tick();
        resetn = 1'b0;
        #1;
        check("arst_pc", pc, 0);
        check("arst_mem_addr", mem_addr, 0);
        check("arst_ir", ir, 0);
        check("arst_busy", busy, 0);
        check("arst_run", run, 0);
        tick();
        build_exp();
        resetn = 1'b1;
        wait_run(1'b0, lat);
        check("arst_restart_lat", lat, 3);
        resetn = 1'b0;
        #1;
        check("arst_issue_run", run, 0);
        check("arst_issue_ir", ir, 0);
        tick();
        build_exp();
        resetn = 1'b1;
        wait_run(1'b0, lat);
        check("restart_ir", ir, 9'o320);
        check("restart_pc", pc, 1);
        pulse_done(1'b0, 1);
        wait_halt();
        check("restart_end_pc", pc, 2);

        // start dropped mid-instruction: park in IDLE, resume at saved pc
        rom_fill();
        rom[0] = 9'o211; rom[1] = 9'o320;
        build_exp();
        do_reset();
        start = 1'b1;
        wait_run(1'b0, lat);
        start = 1'b0;
        pulse_done(1'b0, 2);
        check("park_busy", busy, 0);
        check("park_pc", pc, 1);
        repeat (6) tick();
        check("park_runs", run_cnt, 1);
        check("park_busy_late", busy, 0);
        check("park_halted", halted, 0);
        start = 1'b1;
        wait_run(1'b0, lat);
        check("resume_latency", lat, 3);
        check("resume_ir", ir, 9'o320);
        pulse_done(1'b0, 1);
        wait_halt();
        check("resume_pc", pc, exp_pc);
        check("resume_runs", run_cnt, 2);
        check("resume_queue_left", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
